// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: one state per cycle, with
// a bounded wait on mem_ready in FETCH, MEMRD and MEMWR.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcen,
    output logic       illegal_op,
    output logic       mem_err
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_state;
    logic             timeout;
    logic             known_op;
    logic             pcwrite;
    logic             branch;

    assign wait_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign timeout    = wait_state && !mem_ready && (wait_cnt == TIMEOUT);
    assign known_op   = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                        (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            // The counter only survives a cycle that stays in a wait state without a timeout.
            wait_cnt <= (wait_state && !mem_ready && !timeout) ? wait_cnt + CNT_W'(1) : '0;
            case (state)
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR: state <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD: begin
                    if (mem_ready)    state <= MEMWB;
                    else if (timeout) state <= FETCH;
                end
                MEMWR:  if (mem_ready || timeout) state <= FETCH;
                EXEC:   state <= ALUWB;
                ADDIEX: state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs follow the state register; reset gates them directly so strobes
    // drop the moment reset asserts rather than at the next edge.
    always_comb begin
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                    mem_err = timeout;
                end
                DECODE: begin
                    alusrcb    = 2'b11;
                    illegal_op = !known_op;
                end
                MEMADR, ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    iord    = 1'b1;
                    mem_err = timeout;
                end
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = !timeout;
                    mem_err  = timeout;
                end
                EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                ADDIWB: regwrite = 1'b1;
                JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
        pcen = pcwrite | (branch & zero);
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: fixed vector table, hand-written wait/timeout/reset
// sequences, then random stimulus against a queue-based instruction-plan model.
module tb_mips_multicycle_ctrl;

    localparam int TO = 15;

    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcen;
        logic       illegal_op;
        logic       mem_err;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        logic       ready;
        outs_t      exp;
        string      tag;
    } vec_t;

    function automatic outs_t mk(input logic mw, irw, rw, asa, ird, m2r, rdst,
                                 input logic [1:0] asb, pcs, aop,
                                 input logic pce, ill, merr);
        outs_t o;
        o = '{mw, irw, rw, asa, ird, m2r, rdst, asb, pcs, aop, pce, ill, merr};
        return o;
    endfunction

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    localparam outs_t Z       = '0;
    localparam outs_t F_RDY   = mk(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,0,0);
    localparam outs_t F_WAIT  = mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    localparam outs_t F_TO    = mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,1);
    localparam outs_t DEC     = mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
    localparam outs_t DEC_ILL = mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1,0);
    localparam outs_t ADR     = mk(0,0,0,1,0,0,0,2'b10,2'b00,2'b00,0,0,0);
    localparam outs_t RD      = mk(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0,0);
    localparam outs_t RD_TO   = mk(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0,1);
    localparam outs_t MWB     = mk(0,0,1,0,0,1,0,2'b00,2'b00,2'b00,0,0,0);
    localparam outs_t WR      = mk(1,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0,0);
    localparam outs_t WR_TO   = mk(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0,1);
    localparam outs_t EX      = mk(0,0,0,1,0,0,0,2'b00,2'b00,2'b10,0,0,0);
    localparam outs_t AWB     = mk(0,0,1,0,0,0,1,2'b00,2'b00,2'b00,0,0,0);
    localparam outs_t BR1     = mk(0,0,0,1,0,0,0,2'b00,2'b01,2'b01,1,0,0);
    localparam outs_t BR0     = mk(0,0,0,1,0,0,0,2'b00,2'b01,2'b01,0,0,0);
    localparam outs_t IWB     = mk(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    localparam outs_t JP      = mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,1,0,0);

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       pcen, illegal_op, mem_err;
    outs_t      act;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen),
        .illegal_op(illegal_op), .mem_err(mem_err)
    );

    assign act = {memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                  alusrcb, pcsrc, aluop, pcen, illegal_op, mem_err};

    task automatic check(input string name, input outs_t got, input outs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: outputs %h, expected %h", name, $time, got, want);
        end
    endtask

    // Drive one cycle of inputs just after the edge, compare mid-cycle, advance.
    task automatic step(input logic [5:0] o, input logic z, input logic r,
                        input outs_t want, input string tag, input bit show);
        op = o;
        zero = z;
        mem_ready = r;
        @(negedge clk);
        if (show)
            $display("%0t %-12s op=%b z=%b rdy=%b rst=%b outs=%h", $time, tag, o, z, r, reset, act);
        check(tag, act, want);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] o, input logic z, input logic r,
                       input outs_t want, input string tag);
        vec_t v;
        v.op = o; v.zero = z; v.ready = r; v.exp = want; v.tag = tag;
        tbl.push_back(v);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step(LW, 1'b1, 1'b1, Z, "reset", 1'b1);
        reset = 1'b1;
    endtask

    // Reference model: an instruction is a plan of phases expanded from its opcode;
    // an empty plan means the controller is fetching.
    localparam int T_DEC = 0, T_ADR = 1, T_RD = 2, T_MWB = 3, T_WR = 4, T_EX = 5;
    localparam int T_AWB = 6, T_BR = 7, T_ADDI = 8, T_IWB = 9, T_JMP = 10;
    int plan[$];
    int mcnt = 0;
    int n_instr = 0;

    task automatic model(input logic rst_n, input logic [5:0] o, input logic z,
                         input logic rdy, output outs_t e);
        int tok;
        e = '0;
        if (!rst_n) begin
            plan.delete();
            mcnt = 0;
        end else if (plan.size() == 0) begin
            e.alusrcb = 2'b01;
            if (rdy) begin
                e.irwrite = 1'b1;
                e.pcen = 1'b1;
                plan.push_back(T_DEC);
                mcnt = 0;
            end else if (mcnt == TO) begin
                e.mem_err = 1'b1;
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end else begin
            tok = plan.pop_front();
            case (tok)
                T_DEC: begin
                    e.alusrcb = 2'b11;
                    n_instr++;
                    $display("%0t instr %0d decode op=%b", $time, n_instr, o);
                    case (o)
                        LW, SW: plan.push_back(T_ADR);
                        RT:     begin plan.push_back(T_EX); plan.push_back(T_AWB); end
                        BEQ:    plan.push_back(T_BR);
                        ADDI:   begin plan.push_back(T_ADDI); plan.push_back(T_IWB); end
                        JMP:    plan.push_back(T_JMP);
                        default: e.illegal_op = 1'b1;
                    endcase
                end
                T_ADR, T_ADDI: begin
                    e.alusrca = 1'b1;
                    e.alusrcb = 2'b10;
                    if (tok == T_ADR) begin
                        if (o == LW) begin plan.push_back(T_RD); plan.push_back(T_MWB); end
                        else plan.push_back(T_WR);
                    end
                end
                T_RD, T_WR: begin
                    e.iord = 1'b1;
                    e.memwrite = (tok == T_WR);
                    if (rdy) begin
                        mcnt = 0;
                    end else if (mcnt == TO) begin
                        e.mem_err = 1'b1;
                        e.memwrite = 1'b0;
                        plan.delete();
                        mcnt = 0;
                    end else begin
                        mcnt++;
                        plan.push_front(tok);
                    end
                end
                T_MWB: begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
                T_EX:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
                T_AWB: begin e.regwrite = 1'b1; e.regdst = 1'b1; end
                T_BR:  begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
                T_IWB: e.regwrite = 1'b1;
                T_JMP: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [5:0] legal [6];
        outs_t e;
        int ready_pct;
        int rst_left;
        logic [5:0] ro;
        logic rz, rr;

        legal = '{LW, SW, RT, BEQ, ADDI, JMP};
        reset = 1'b0;
        op = '0;
        zero = 1'b0;
        mem_ready = 1'b1;

        apply_reset();

        add(LW, 0, 0, F_WAIT, "fetch.wait");
        add(LW, 0, 1, F_RDY, "lw.fetch");  add(LW, 0, 1, DEC, "lw.dec");
        add(LW, 0, 1, ADR, "lw.adr");      add(LW, 0, 1, RD, "lw.rd");
        add(LW, 0, 1, MWB, "lw.wb");
        add(SW, 0, 1, F_RDY, "sw.fetch");  add(SW, 0, 1, DEC, "sw.dec");
        add(SW, 0, 1, ADR, "sw.adr");      add(SW, 0, 1, WR, "sw.wr");
        add(RT, 0, 1, F_RDY, "r.fetch");   add(RT, 0, 1, DEC, "r.dec");
        add(RT, 1, 1, EX, "r.exec");       add(RT, 0, 1, AWB, "r.wb");
        add(BEQ, 1, 1, F_RDY, "beq1.fetch"); add(BEQ, 1, 1, DEC, "beq1.dec");
        add(BEQ, 1, 1, BR1, "beq1.br");
        add(BEQ, 0, 1, F_RDY, "beq0.fetch"); add(BEQ, 0, 1, DEC, "beq0.dec");
        add(BEQ, 0, 1, BR0, "beq0.br");
        add(JMP, 0, 1, F_RDY, "j.fetch");  add(JMP, 0, 1, DEC, "j.dec");
        add(JMP, 0, 1, JP, "j.jump");
        add(ADDI, 0, 1, F_RDY, "addi.fetch"); add(ADDI, 0, 1, DEC, "addi.dec");
        add(ADDI, 0, 1, ADR, "addi.ex");      add(ADDI, 0, 1, IWB, "addi.wb");
        add(6'b111111, 0, 1, F_RDY, "ill.fetch"); add(6'b111111, 0, 1, DEC_ILL, "ill.dec");
        add(6'b000001, 0, 1, F_RDY, "ill2.fetch"); add(6'b000001, 0, 1, DEC_ILL, "ill2.dec");
        add(LW, 0, 1, F_RDY, "after.ill");
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].op, tbl[i].zero, tbl[i].ready, tbl[i].exp, tbl[i].tag, 1'b1);

        // sw held off three cycles: memwrite stays high for four
        apply_reset();
        step(SW, 0, 1, F_RDY, "swh.fetch", 1'b1);
        step(SW, 0, 1, DEC, "swh.dec", 1'b1);
        step(SW, 0, 1, ADR, "swh.adr", 1'b1);
        for (int i = 0; i < 3; i++) step(SW, 0, 0, WR, "swh.wait", 1'b1);
        step(SW, 0, 1, WR, "swh.done", 1'b1);
        step(SW, 0, 1, F_RDY, "swh.next", 1'b1);

        // MEMRD timeout after TO waiting cycles
        step(LW, 0, 1, DEC, "rto.dec", 1'b1);
        step(LW, 0, 1, ADR, "rto.adr", 1'b1);
        for (int i = 0; i < TO; i++) step(LW, 0, 0, RD, "rto.wait", 1'b0);
        step(LW, 0, 0, RD_TO, "rto.timeout", 1'b1);
        step(LW, 0, 1, F_RDY, "rto.fetch", 1'b1);

        // ready arriving exactly on the timeout cycle completes normally
        step(LW, 0, 1, DEC, "rlate.dec", 1'b1);
        step(LW, 0, 1, ADR, "rlate.adr", 1'b1);
        for (int i = 0; i < TO; i++) step(LW, 0, 0, RD, "rlate.wait", 1'b0);
        step(LW, 0, 1, RD, "rlate.ready", 1'b1);
        step(LW, 0, 1, MWB, "rlate.wb", 1'b1);

        // MEMWR timeout suppresses memwrite on the error cycle
        step(SW, 0, 1, F_RDY, "wto.fetch", 1'b1);
        step(SW, 0, 1, DEC, "wto.dec", 1'b1);
        step(SW, 0, 1, ADR, "wto.adr", 1'b1);
        for (int i = 0; i < TO; i++) step(SW, 0, 0, WR, "wto.wait", 1'b0);
        step(SW, 0, 0, WR_TO, "wto.timeout", 1'b1);

        // FETCH timeout retries fetch with a cleared counter
        for (int i = 0; i < TO; i++) step(LW, 0, 0, F_WAIT, "fto.wait", 1'b0);
        step(LW, 0, 0, F_TO, "fto.timeout", 1'b1);
        step(LW, 0, 0, F_WAIT, "fto.retry", 1'b1);
        step(LW, 0, 1, F_RDY, "fto.fetch", 1'b1);

        // reset asserted mid-MEMWR drops memwrite without waiting for an edge
        step(SW, 0, 1, DEC, "rstw.dec", 1'b1);
        step(SW, 0, 1, ADR, "rstw.adr", 1'b1);
        op = SW; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("rstw.wr", act, WR);
        #2;
        reset = 1'b0;
        #1;
        $display("%0t %-12s rst=%b outs=%h", $time, "rstw.async", reset, act);
        check("rstw.async", act, Z);
        @(posedge clk);
        #1;
        step(SW, 0, 1, Z, "rstw.held", 1'b1);
        reset = 1'b1;
        step(SW, 0, 1, F_RDY, "rstw.fetch", 1'b1);

        // randomized run against the plan model
        apply_reset();
        plan.delete();
        mcnt = 0;
        ready_pct = 100;
        rst_left = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: ready_pct = 100;
                    1: ready_pct = 70;
                    2: ready_pct = 30;
                    default: ready_pct = 0;
                endcase
            end
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 2);
            reset = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            ro = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 5)] : 6'($urandom);
            rz = 1'($urandom);
            rr = ($urandom_range(0, 99) < ready_pct);
            model(reset, ro, rz, rr, e);
            step(ro, rz, rr, e, "rnd", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
